// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: WB control layout, FSM encoding, defaults.
package mem_stage_pkg;

  localparam int unsigned WB_W            = 2;
  localparam int unsigned WB_REGWRITE     = 1;
  localparam int unsigned WB_MEMTOREG     = 0;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned RD_W            = 5;
  localparam int unsigned BR_W            = 7;

  localparam int unsigned ACK_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wait_ctrl.sv
// Wait-state controller: tracks an outstanding data-memory access, counts wait
// cycles, aborts on timeout and raises a sticky error flag.
module mem_wait_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic access,
  input  logic mem_ack,
  output logic stall,
  output logic timeout_hit,
  output logic mem_error
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  // State, wait counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus the stall/timeout indications seen by the stage this cycle.
  // Timeout is only meaningful while the access is still held; a dropped access
  // simply returns to IDLE without an error.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    timeout_hit = (state_q == ST_WAIT) & access & ~mem_ack &
                  (cnt_q == CNT_W'(ACK_TIMEOUT));
    stall       = access & ~mem_ack & ~timeout_hit;

    case (state_q)
      ST_IDLE: begin
        if (access & ~mem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (~access | mem_ack) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_error = err_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory req/ack port, resolves branches,
// stalls upstream during wait states and registers results into MEM/WB.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] aluResult,
  input  logic [DATA_W-1:0] writeData,
  input  logic [BR_W-1:0]   branchAddress,
  input  logic [RD_W-1:0]   rd,
  input  logic [WB_W-1:0]   wb,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              branch,
  input  logic              ZF,
  input  logic              BNE,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck,
  output logic              stall,
  output logic              pcSrc,
  output logic [BR_W-1:0]   pcBranch,
  output logic [DATA_W-1:0] memWbReadData,
  output logic [ADDR_W-1:0] memWbAluResult,
  output logic [RD_W-1:0]   memWbRd,
  output logic [WB_W-1:0]   memWbWb,
  output logic              memError
);

  logic access;
  logic timeout_hit;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] alu_q,   alu_d;
  logic [RD_W-1:0]   rd_q,    rd_d;
  logic [WB_W-1:0]   wb_q,    wb_d;

  // Memory port and branch resolution are pass-through; write wins over read.
  always_comb begin
    access   = memRead | memWrite;
    memReq   = access;
    memWe    = memWrite;
    memAddr  = aluResult;
    memWdata = writeData;
    pcSrc    = branch & (ZF ^ BNE);
    pcBranch = branchAddress;
  end

  mem_wait_ctrl #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_ctrl (
    .clock       (clock),
    .reset       (reset),
    .access      (access),
    .mem_ack     (memAck),
    .stall       (stall),
    .timeout_hit (timeout_hit),
    .mem_error   (memError)
  );

  // MEM/WB next values: bubble while stalled, otherwise capture; an aborted
  // access squashes WB control (including regWrite) and zeroes the load data.
  always_comb begin
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    wb_d    = wb_q;
    if (stall) begin
      rd_d = '0;
      wb_d = '0;
    end else begin
      alu_d = aluResult;
      rd_d  = rd;
      wb_d  = timeout_hit ? '0 : wb;
      if (memRead & memAck) begin
        rdata_d = memRdata;
      end else if (timeout_hit) begin
        rdata_d = '0;
      end
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      wb_q    <= '0;
    end else begin
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      wb_q    <= wb_d;
    end
  end

  assign memWbReadData  = rdata_q;
  assign memWbAluResult = alu_q;
  assign memWbRd        = rd_q;
  assign memWbWb        = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single-cycle vectors plus
// hand-written wait-state, timeout and reset-mid-access sequences.
module tb_mem_stage;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] aluResult, writeData, memRdata;
  logic [6:0]  branchAddress;
  logic [4:0]  rd;
  logic [1:0]  wb;
  logic        memRead, memWrite, branch, ZF, BNE, memAck;
  logic        memReq, memWe, stall, pcSrc, memError;
  logic [31:0] memAddr, memWdata, memWbReadData, memWbAluResult;
  logic [6:0]  pcBranch;
  logic [4:0]  memWbRd;
  logic [1:0]  memWbWb;

  mem_stage #(.ACK_TIMEOUT(TO), .CNT_W(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .aluResult      (aluResult),
    .writeData      (writeData),
    .branchAddress  (branchAddress),
    .rd             (rd),
    .wb             (wb),
    .memRead        (memRead),
    .memWrite       (memWrite),
    .branch         (branch),
    .ZF             (ZF),
    .BNE            (BNE),
    .memReq         (memReq),
    .memWe          (memWe),
    .memAddr        (memAddr),
    .memWdata       (memWdata),
    .memRdata       (memRdata),
    .memAck         (memAck),
    .stall          (stall),
    .pcSrc          (pcSrc),
    .pcBranch       (pcBranch),
    .memWbReadData  (memWbReadData),
    .memWbAluResult (memWbAluResult),
    .memWbRd        (memWbRd),
    .memWbWb        (memWbWb),
    .memError       (memError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  wb;
  } mw_t;

  typedef struct {
    logic        rd_en, wr_en, br, zf, bne, ack;
    logic [31:0] alu, wdata, rdata;
    logic [6:0]  baddr;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        e_req, e_we, e_pc;
    mw_t         e_mw;
  } vec_t;

  mw_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  function automatic mw_t mw(input logic [31:0] rdata, input logic [31:0] alu,
                             input logic [4:0] r, input logic [1:0] w);
    mw_t m;
    m.rdata = rdata; m.alu = alu; m.rd = r; m.wb = w;
    return m;
  endfunction

  function automatic vec_t mkv(input logic rd_en, input logic wr_en, input logic br,
                               input logic zf, input logic bne, input logic ack,
                               input logic [31:0] alu, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic [6:0] baddr,
                               input logic [4:0] r, input logic [1:0] w,
                               input logic e_req, input logic e_we, input logic e_pc,
                               input mw_t e_mw);
    vec_t v;
    v.rd_en = rd_en; v.wr_en = wr_en; v.br = br; v.zf = zf; v.bne = bne; v.ack = ack;
    v.alu = alu; v.wdata = wdata; v.rdata = rdata; v.baddr = baddr; v.rd = r; v.wb = w;
    v.e_req = e_req; v.e_we = e_we; v.e_pc = e_pc; v.e_mw = e_mw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_mw(input string tag);
    mw_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".rdata"}, memWbReadData, e.rdata);
      chk({tag, ".alu"},   memWbAluResult, e.alu);
      chk({tag, ".rd"},    32'(memWbRd), 32'(e.rd));
      chk({tag, ".wb"},    32'(memWbWb), 32'(e.wb));
    end
  endtask

  // One clock: check stall mid-cycle, queue expected MEM/WB, compare after the edge.
  task automatic cycle(input string tag, input logic exp_stall, input mw_t e);
    #2;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clock);
    #1;
    check_mw(tag);
  endtask

  task automatic drive(input vec_t v);
    memRead = v.rd_en; memWrite = v.wr_en; branch = v.br; ZF = v.zf; BNE = v.bne;
    memAck = v.ack; aluResult = v.alu; writeData = v.wdata; memRdata = v.rdata;
    branchAddress = v.baddr; rd = v.rd; wb = v.wb;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    memRead = 0; memWrite = 0; branch = 0; ZF = 0; BNE = 0; memAck = 0;
    aluResult = '0; writeData = '0; memRdata = '0; branchAddress = '0; rd = '0; wb = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.rdata", memWbReadData, 32'h0);
    chk("rst.alu",   memWbAluResult, 32'h0);
    chk("rst.rd",    32'(memWbRd), 32'h0);
    chk("rst.wb",    32'(memWbWb), 32'h0);
    chk("rst.err",   32'(memError), 32'h0);
    chk("rst.stall", 32'(stall), 32'h0);
    reset = 1'b0;

    //               rd wr br zf bn ak  alu           wdata         rdata         baddr  rd     wb     req we pc  expected MEM/WB
    vecs[0] = mkv(1, 0, 0, 0, 0, 1, 32'h40,       32'h0,        32'hDEADBEEF, 7'h00, 5'd5, 2'b11, 1, 0, 0, mw(32'hDEADBEEF, 32'h40, 5'd5, 2'b11));
    vecs[1] = mkv(0, 1, 0, 0, 0, 1, 32'h80,       32'h55,       32'h11111111, 7'h00, 5'd3, 2'b00, 1, 1, 0, mw(32'hDEADBEEF, 32'h80, 5'd3, 2'b00));
    vecs[2] = mkv(0, 0, 1, 1, 0, 0, 32'h7,        32'h0,        32'h0,        7'h2A, 5'd0, 2'b00, 0, 0, 1, mw(32'hDEADBEEF, 32'h7,  5'd0, 2'b00));
    vecs[3] = mkv(0, 0, 1, 1, 1, 0, 32'h8,        32'h0,        32'h0,        7'h2A, 5'd0, 2'b00, 0, 0, 0, mw(32'hDEADBEEF, 32'h8,  5'd0, 2'b00));
    vecs[4] = mkv(0, 0, 1, 0, 1, 0, 32'h9,        32'h0,        32'h0,        7'h15, 5'd0, 2'b00, 0, 0, 1, mw(32'hDEADBEEF, 32'h9,  5'd0, 2'b00));
    vecs[5] = mkv(0, 0, 1, 0, 0, 0, 32'hA,        32'h0,        32'h0,        7'h7F, 5'd0, 2'b00, 0, 0, 0, mw(32'hDEADBEEF, 32'hA,  5'd0, 2'b00));
    vecs[6] = mkv(1, 1, 0, 0, 0, 1, 32'h100,      32'h99,       32'hCAFEF00D, 7'h00, 5'd7, 2'b10, 1, 1, 0, mw(32'hCAFEF00D, 32'h100, 5'd7, 2'b10));
    vecs[7] = mkv(0, 0, 0, 0, 0, 0, 32'h12345678, 32'h0,        32'h0,        7'h00, 5'd9, 2'b10, 0, 0, 0, mw(32'hCAFEF00D, 32'h12345678, 5'd9, 2'b10));

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i]);
      #2;
      chk({tag, ".req"},   32'(memReq), 32'(vecs[i].e_req));
      chk({tag, ".we"},    32'(memWe),  32'(vecs[i].e_we));
      chk({tag, ".pcsrc"}, 32'(pcSrc),  32'(vecs[i].e_pc));
      chk({tag, ".pcbr"},  32'(pcBranch), 32'(vecs[i].baddr));
      chk({tag, ".addr"},  memAddr,  vecs[i].alu);
      chk({tag, ".wdata"}, memWdata, vecs[i].wdata);
      chk({tag, ".stall"}, 32'(stall), 32'h0);
      sb.push_back(vecs[i].e_mw);
      @(posedge clock);
      #1;
      check_mw(tag);
      chk({tag, ".err"}, 32'(memError), 32'h0);
    end

    // Store with two wait states.
    branch = 0; ZF = 0; BNE = 0; branchAddress = '0;
    memRead = 0; memWrite = 1; writeData = 32'h1234; aluResult = 32'h200;
    rd = 5'd4; wb = 2'b01; memAck = 0;
    #1 chk("st.w1.we", 32'(memWe), 32'h1);
    cycle("st.w1", 1'b1, mw(32'hCAFEF00D, 32'h12345678, 5'd0, 2'b00));
    chk("st.w2.we", 32'(memWe), 32'h1);
    cycle("st.w2", 1'b1, mw(32'hCAFEF00D, 32'h12345678, 5'd0, 2'b00));
    memAck = 1;
    #1 chk("st.ack.we", 32'(memWe), 32'h1);
    cycle("st.ack", 1'b0, mw(32'hCAFEF00D, 32'h200, 5'd4, 2'b01));
    chk("st.err", 32'(memError), 32'h0);

    // Load that never gets an ack: aborts after TO wait cycles.
    memWrite = 0; memRead = 1; aluResult = 32'h300; rd = 5'd6; wb = 2'b11;
    memAck = 0; memRdata = 32'hFFFFFFFF;
    for (int k = 0; k < TO; k++)
      cycle($sformatf("to.w%0d", k + 1), 1'b1, mw(32'hCAFEF00D, 32'h200, 5'd0, 2'b00));
    cycle("to.abort", 1'b0, mw(32'h0, 32'h300, 5'd6, 2'b00));
    chk("to.err", 32'(memError), 32'h1);
    memRead = 0; aluResult = 32'h9; rd = 5'd1; wb = 2'b10;
    cycle("to.idle", 1'b0, mw(32'h0, 32'h9, 5'd1, 2'b10));
    chk("to.sticky", 32'(memError), 32'h1);

    // Reset during the second wait cycle of a load.
    memRead = 1; aluResult = 32'h400; rd = 5'd8; wb = 2'b11; memAck = 0; memRdata = 32'h77;
    cycle("rs.w1", 1'b1, mw(32'h0, 32'h9, 5'd0, 2'b00));
    reset = 1;
    cycle("rs.edge", 1'b1, mw(32'h0, 32'h0, 5'd0, 2'b00));
    chk("rs.err", 32'(memError), 32'h0);
    reset = 0;
    memAck = 1; memRdata = 32'hA5A5A5A5; aluResult = 32'h44; rd = 5'd2; wb = 2'b11;
    cycle("rs.load", 1'b0, mw(32'hA5A5A5A5, 32'h44, 5'd2, 2'b11));
    chk("rs.load.err", 32'(memError), 32'h0);

    // After reset the wait counter starts afresh: full TO wait cycles again.
    memAck = 0; aluResult = 32'h500; rd = 5'd3; wb = 2'b11;
    for (int k = 0; k < TO; k++)
      cycle($sformatf("rs.to.w%0d", k + 1), 1'b1, mw(32'hA5A5A5A5, 32'h44, 5'd0, 2'b00));
    cycle("rs.to.abort", 1'b0, mw(32'h0, 32'h500, 5'd3, 2'b00));
    chk("rs.to.err", 32'(memError), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
